// File: rtl/trap_ctrl.sv
// Machine-mode trap/interrupt sequencer: owns mstatus/mie/mip and mtimecmp and decides
// ECALL, MRET and interrupt entry at retire boundaries, then drives redirect and settle.
module trap_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] cycle,
  input  logic        cmp_we,
  input  logic        cmp_hi,
  input  logic [31:0] cmp_wdata,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        irq_ext,
  input  logic        ret_valid,
  input  logic [31:0] ret_pc,
  input  logic [31:0] ret_npc,
  input  logic        ret_ecall,
  input  logic        ret_mret,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        trap_req,
  output logic        redirect,
  output logic [31:0] trap_pc,
  output logic [31:0] trap_epc,
  output logic [31:0] trap_cause,
  output logic        stall,
  output logic [31:0] mstatus_q,
  output logic [31:0] mie_q,
  output logic [31:0] mip_q
);

  localparam int unsigned XLEN = 32;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [31:0] CAUSE_ECALL = 32'h0000_000B;
  localparam logic [31:0] CAUSE_MEI   = 32'h8000_000B;
  localparam logic [31:0] CAUSE_MTI   = 32'h8000_0007;

  typedef enum logic [1:0] {RUN, TRAP, SETTLE} state_t;

  state_t      state;
  logic        st_mie;
  logic        st_mpie;
  logic        en_mtie;
  logic        en_meie;
  logic [63:0] mtimecmp;
  logic        sync1;
  logic        sync2;

  logic            mtip;
  logic            meip;
  logic            ext_hit;
  logic            tmr_hit;
  logic            irq;
  logic [31:0]     int_cause;
  logic [XLEN-1:0] vec_base;
  logic [XLEN-1:0] int_target;
  logic            mstatus_wr;
  logic            mie_wr;
  logic            unused_bits;

  assign unused_bits = ^csr_wdata;

  assign mtip       = (cycle >= mtimecmp);
  assign meip       = sync2;
  assign mstatus_wr = csr_we && (csr_addr == CSR_MSTATUS);
  assign mie_wr     = csr_we && (csr_addr == CSR_MIE);

  assign mstatus_q = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
  assign mie_q     = {20'b0, en_meie, 3'b0, en_mtie, 7'b0};
  assign mip_q     = {20'b0, meip, 3'b0, mtip, 7'b0};

  // Interrupt selection: external beats timer; vectored mode offsets by 4*cause.
  always_comb begin
    ext_hit    = meip && en_meie;
    tmr_hit    = mtip && en_mtie;
    irq        = st_mie && (ext_hit || tmr_hit);
    int_cause  = ext_hit ? CAUSE_MEI : CAUSE_MTI;
    vec_base   = {mtvec[31:2], 2'b00};
    int_target = vec_base;
    if (mtvec[1:0] == 2'b01) begin
      int_target = vec_base + XLEN'({int_cause[4:0], 2'b00});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= irq_ext;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtimecmp <= '1;
      en_mtie  <= 1'b0;
      en_meie  <= 1'b0;
    end else begin
      if (cmp_we) begin
        if (cmp_hi) mtimecmp[63:32] <= cmp_wdata;
        else        mtimecmp[31:0]  <= cmp_wdata;
      end
      if (mie_wr) begin
        en_mtie <= csr_wdata[7];
        en_meie <= csr_wdata[11];
      end
    end
  end

  // Sequencer; a trap decision's MIE/MPIE update overrides a same-cycle mstatus write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      trap_req   <= 1'b0;
      redirect   <= 1'b0;
      stall      <= 1'b0;
      trap_pc    <= '0;
      trap_epc   <= '0;
      trap_cause <= '0;
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
    end else begin
      trap_req <= 1'b0;
      redirect <= 1'b0;
      stall    <= 1'b0;
      if (mstatus_wr) begin
        st_mie  <= csr_wdata[3];
        st_mpie <= csr_wdata[7];
      end
      case (state)
        RUN: begin
          if (ret_valid) begin
            if (ret_ecall) begin
              state      <= TRAP;
              trap_req   <= 1'b1;
              redirect   <= 1'b1;
              trap_pc    <= vec_base;
              trap_epc   <= ret_pc;
              trap_cause <= CAUSE_ECALL;
              st_mpie    <= st_mie;
              st_mie     <= 1'b0;
            end else if (ret_mret) begin
              state    <= TRAP;
              redirect <= 1'b1;
              trap_pc  <= mepc;
              st_mie   <= st_mpie;
              st_mpie  <= 1'b1;
            end else if (irq) begin
              state      <= TRAP;
              trap_req   <= 1'b1;
              redirect   <= 1'b1;
              trap_pc    <= int_target;
              trap_epc   <= ret_npc;
              trap_cause <= int_cause;
              st_mpie    <= st_mie;
              st_mie     <= 1'b0;
            end
          end
        end
        TRAP: begin
          stall <= 1'b1;
          state <= SETTLE;
        end
        SETTLE: state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule
